// File: rtl/dataflow_switch_ctrl.sv
// ============================================================================
//  Module      : dataflow_switch_ctrl
//  Description : Select-line sequencer for the two-source MIPI dataflow switch.
//                Optional drain timeout enabled by defining DFS_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dataflow_switch_ctrl #(
    parameter int IDLE_CYCLES    = 16,
    parameter int GUARD_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter bit RESET_SEL      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sel,
    input  logic [1:0] lp0_out_a,
    input  logic       hs_clk_en_a,
    input  logic       hs_data_en_a,
    input  logic [1:0] lp0_out_b,
    input  logic       hs_clk_en_b,
    input  logic       hs_data_en_b,
    output logic       o_state,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_timeout
);

    localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    localparam logic [IDLE_W-1:0]  C_IDLE_MAX   = IDLE_W'(IDLE_CYCLES);
    localparam logic [GUARD_W-1:0] C_GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t             r_st;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [GUARD_W-1:0] r_guard_cnt;

    logic              w_idle_a;
    logic              w_idle_b;
    logic              w_qual;
    logic              w_req;
    logic [IDLE_W-1:0] w_idle_inc;
    logic              w_to_hit;

    // A source is quiet only in LP-11 stop state with both HS enables low.
    assign w_idle_a   = (lp0_out_a == 2'b11) & ~hs_clk_en_a & ~hs_data_en_a;
    assign w_idle_b   = (lp0_out_b == 2'b11) & ~hs_clk_en_b & ~hs_data_en_b;
    assign w_qual     = w_idle_a & w_idle_b;
    assign w_req      = (i_sel != o_state);
    assign w_idle_inc = (r_idle_cnt == C_IDLE_MAX) ? r_idle_cnt : r_idle_cnt + IDLE_W'(1);

`ifdef DFS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TO_W-1:0] C_TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;

    assign w_to_hit = (r_st == ST_DRAIN) && (r_to_cnt == C_TO_LAST);

    // Held at zero outside DRAIN, so every DRAIN entry starts a fresh budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= w_to_hit && w_req;
            if (r_st == ST_DRAIN) begin
                if (r_to_cnt != C_TO_MAX) begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end
`else
    assign w_to_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st        <= ST_RUN;
            o_state     <= RESET_SEL;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            r_idle_cnt  <= '0;
            r_guard_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_st)
                ST_RUN: begin
                    if (w_req) begin
                        r_st       <= ST_DRAIN;
                        o_busy     <= 1'b1;
                        r_idle_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Withdrawal outranks both the forced and the qualified exits.
                    if (!w_req) begin
                        r_st   <= ST_RUN;
                        o_busy <= 1'b0;
                    end else if (w_to_hit) begin
                        r_st    <= ST_RUN;
                        o_busy  <= 1'b0;
                        o_state <= ~o_state;
                        o_done  <= 1'b1;
                    end else if (w_qual) begin
                        r_idle_cnt <= w_idle_inc;
                        if (w_idle_inc == C_IDLE_MAX) begin
                            r_st        <= ST_GUARD;
                            r_guard_cnt <= '0;
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end
                ST_GUARD: begin
                    // Commit is unconditional once the guard interval has started.
                    if (r_guard_cnt == C_GUARD_LAST) begin
                        r_st    <= ST_RUN;
                        o_busy  <= 1'b0;
                        o_state <= ~o_state;
                        o_done  <= 1'b1;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + GUARD_W'(1);
                    end
                end
                default: begin
                    r_st   <= ST_RUN;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dataflow_switch_ctrl.sv
// ============================================================================
//  Module      : tb_dataflow_switch_ctrl
//  Description : Scoreboard bench for dataflow_switch_ctrl; timeout scenarios
//                are built when DFS_TIMEOUT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dataflow_switch_ctrl;

`ifdef DFS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_sel = 1'b0;
    logic [1:0] lp0_out_a = 2'b11;
    logic       hs_clk_en_a = 1'b0;
    logic       hs_data_en_a = 1'b0;
    logic [1:0] lp0_out_b = 2'b11;
    logic       hs_clk_en_b = 1'b0;
    logic       hs_data_en_b = 1'b0;
    logic       o_state;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout;

    dataflow_switch_ctrl #(
        .IDLE_CYCLES    (16),
        .GUARD_CYCLES   (8),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .RESET_SEL      (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_sel        (i_sel),
        .lp0_out_a    (lp0_out_a),
        .hs_clk_en_a  (hs_clk_en_a),
        .hs_data_en_a (hs_data_en_a),
        .lp0_out_b    (lp0_out_b),
        .hs_clk_en_b  (hs_clk_en_b),
        .hs_data_en_b (hs_data_en_b),
        .o_state      (o_state),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   at;
        logic st;
        logic to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int at, input logic st, input logic to);
        exp_t e;
        e.at = at;
        e.st = st;
        e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic go(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every o_done pulse must match the oldest expected switch event.
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: o_done=1 with no switch expected (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.at);
                chk("done_state", {31'd0, o_state}, {31'd0, mon_e.st});
                chk("done_timeout", {31'd0, o_timeout}, {31'd0, mon_e.to});
            end
        end else begin
            chk("timeout_without_done", {31'd0, o_timeout}, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int d;

        // Reset held two clocks
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {31'd0, o_state}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        chk("reset_timeout", {31'd0, o_timeout}, 32'd0);
        rst = 1'b0;

        // Straight A->B switch, both sources idle
        go(cyc + 2);
        c = cyc;
        i_sel = 1'b1;
        push(c + 25, 1'b1, 1'b0);
        go(c + 1);
        chk("sw_busy_rise", {31'd0, o_busy}, 32'd1);
        chk("sw_state_held", {31'd0, o_state}, 32'd0);
        go(c + 26);
        chk("sw_state_after", {31'd0, o_state}, 32'd1);
        chk("sw_busy_after", {31'd0, o_busy}, 32'd0);

        // B->A with a one-clock HS burst at idle count 10
        c = cyc;
        i_sel = 1'b0;
        push(c + 36, 1'b0, 1'b0);
        go(c + 11);
        hs_data_en_a = 1'b1;
        go(c + 12);
        hs_data_en_a = 1'b0;
        go(c + 26);
        chk("burst_no_early_flip", {31'd0, o_state}, 32'd1);
        go(c + 37);
        chk("burst_state_after", {31'd0, o_state}, 32'd0);
        chk("burst_busy_after", {31'd0, o_busy}, 32'd0);

        // Request withdrawn in DRAIN
        c = cyc;
        i_sel = 1'b1;
        go(c + 6);
        i_sel = 1'b0;
        go(c + 7);
        chk("cancel_busy", {31'd0, o_busy}, 32'd0);
        go(c + 45);
        chk("cancel_state", {31'd0, o_state}, 32'd0);

        // Request withdrawn in GUARD: flip anyway, then drain back
        c = cyc;
        i_sel = 1'b1;
        push(c + 25, 1'b1, 1'b0);
        push(c + 50, 1'b0, 1'b0);
        go(c + 20);
        i_sel = 1'b0;
        go(c + 26);
        chk("guard_wd_state", {31'd0, o_state}, 32'd1);
        chk("guard_wd_redrain", {31'd0, o_busy}, 32'd1);
        go(c + 51);
        chk("guard_wd_back", {31'd0, o_state}, 32'd0);
        chk("guard_wd_busy", {31'd0, o_busy}, 32'd0);

        // Reset in GUARD aborts the switch
        c = cyc;
        i_sel = 1'b1;
        go(c + 20);
        chk("rst_guard_busy_pre", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        i_sel = 1'b0;
        go(c + 21);
        chk("rst_guard_state", {31'd0, o_state}, 32'd0);
        chk("rst_guard_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        go(c + 50);
        chk("rst_guard_settled", {31'd0, o_state}, 32'd0);

`ifdef DFS_TIMEOUT_EN
        // Reset at DRAIN clock 50 while source B is stuck in HS
        c = cyc;
        hs_clk_en_b = 1'b1;
        i_sel = 1'b1;
        go(c + 50);
        rst = 1'b1;
        i_sel = 1'b0;
        go(c + 51);
        chk("rst_drain_state", {31'd0, o_state}, 32'd0);
        chk("rst_drain_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;

        // Forced switch after the drain budget
        go(cyc + 2);
        c = cyc;
        i_sel = 1'b1;
        push(c + 101, 1'b1, 1'b1);
        go(c + 100);
        chk("to_not_early", {31'd0, o_state}, 32'd0);
        go(c + 102);
        chk("to_state", {31'd0, o_state}, 32'd1);
        chk("to_busy", {31'd0, o_busy}, 32'd0);
        hs_clk_en_b = 1'b0;
        c = cyc;
        i_sel = 1'b0;
        push(c + 25, 1'b0, 1'b0);
        go(c + 26);
        chk("to_return", {31'd0, o_state}, 32'd0);
`else
        // Non-idle sources hold the switch off indefinitely
        c = cyc;
        lp0_out_a = 2'b01;
        i_sel = 1'b1;
        go(c + 30);
        lp0_out_a = 2'b11;
        hs_clk_en_b = 1'b1;
        go(c + 60);
        chk("hold_busy", {31'd0, o_busy}, 32'd1);
        chk("hold_state", {31'd0, o_state}, 32'd0);
        d = cyc;
        hs_clk_en_b = 1'b0;
        push(d + 24, 1'b1, 1'b0);
        go(d + 25);
        chk("hold_release_state", {31'd0, o_state}, 32'd1);
        c = cyc;
        i_sel = 1'b0;
        push(c + 25, 1'b0, 1'b0);
        go(c + 26);
        chk("hold_return", {31'd0, o_state}, 32'd0);
`endif

        go(cyc + 5);
        chk("pending_events", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
